// File: rtl/ser_tx_arb.sv
// Four-way arbitrated serial byte transmitter: chip-select framing, MSB-first data, inter-frame gap.
// Define SER_TX_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module ser_tx_arb #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        sdo,
    output logic        sclk,
    output logic        cs_n,
    output logic        busy,
    output logic        done
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]    state;
    logic          pend;
    logic [1:0]    win_q;
    logic [7:0]    shreg;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [1:0]    winner;

`ifdef SER_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (req[i-1]) winner = 2'(i - 1);
        end
    end
`else
    logic [1:0] rr;
    logic [1:0] idx;

    // Scan downward so the lowest offset from rr is the last (winning) assignment.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            idx = rr + 2'(i - 1);
            if (req[idx]) winner = idx;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= 1'b0;
            win_q   <= '0;
            shreg   <= '0;
            timer   <= '0;
            bit_idx <= 3'd7;
            ack     <= '0;
            sdo     <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifndef SER_TX_ARB_FIXED_PRIO_EN
            rr      <= '0;
`endif
        end else begin
            ack  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Arbitration edge latches winner and byte; frame starts on the next edge.
                    if (pend) begin
                        pend    <= 1'b0;
                        ack     <= 4'b0001 << win_q;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        sclk    <= 1'b0;
                        sdo     <= shreg[7];
                        timer   <= '0;
                        bit_idx <= 3'd7;
                        state   <= SHIFT;
                    end else if (req != 4'b0000) begin
                        pend  <= 1'b1;
                        win_q <= winner;
                        shreg <= req_data[{winner, 3'b000} +: 8];
`ifndef SER_TX_ARB_FIXED_PRIO_EN
                        rr    <= winner + 2'd1;
`endif
                    end
                end
                SHIFT: begin
                    if (timer != T_LAST) begin
                        timer <= timer + TW'(1);
                    end else begin
                        timer <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            sclk    <= 1'b0;
                            sdo     <= shreg[bit_idx - 3'd1];
                        end else begin
                            cs_n    <= 1'b1;
                            sclk    <= 1'b0;
                            sdo     <= 1'b0;
                            done    <= 1'b1;
                            bit_idx <= 3'd7;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (timer != T_LAST) begin
                        timer <= timer + TW'(1);
                    end else begin
                        timer <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ser_tx_arb.md
Name: ser_tx_arb

Overview:
- Shares one serial byte transmitter between 4 requesters using round-robin arbitration.
- Sequences each frame itself: chip-select, bit clock at a parameterised rate, MSB-first data, then an inter-frame gap.
- Sits between on-chip byte producers and an SPI-style off-chip link.

Parameters:
- CLKS_PER_BIT, default 4: clk cycles per sclk half-period; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  4  per-requester level request; held high until ack
- req_data  in  32  byte for requester i is req_data[8*i+7 : 8*i]
- ack  out  4  one-hot, 1-cycle pulse: byte of requester i accepted
- sdo  out  1  serial data out, MSB first
- sclk  out  1  bit clock, idle low
- cs_n  out  1  frame select, active low
- busy  out  1  high while a frame or gap is in progress
- done  out  1  1-cycle pulse at end of frame

Behaviour:
- Reset values (applied immediately, asynchronously): ack=0, sdo=0, sclk=0, cs_n=1, busy=0, done=0. State=IDLE, rr pointer=0, timer=0, bit index=7.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE, no req: hold all outputs at their reset values.
- IDLE, req != 0 at edge N:
  - Winner = first set bit searching from the rr pointer upward, mod 4.
  - Latch the winner's byte.
  - At edge N+1: ack[winner]=1 for one cycle, cs_n=0, busy=1, sclk=0, sdo=byte[7]. Enter SHIFT; timer=0, bit index=7.
  - rr pointer = winner+1 mod 4.
- SHIFT, per bit:
  - sclk low for CLKS_PER_BIT cycles, then high for CLKS_PER_BIT cycles.
  - sdo changes only at the start of a low phase; it is stable across the rising sclk edge.
  - After the high phase of a bit other than bit 0: decrement bit index, sclk=0, sdo=next bit.
- End of frame, after bit 0's high phase:
  - cs_n=1, sclk=0, sdo=0, done=1 for one cycle. Enter GAP.
  - cs_n is low for exactly 16*CLKS_PER_BIT cycles.
- GAP: lasts CLKS_PER_BIT cycles with busy=1, then IDLE with busy=0. Arbitration resumes on the first IDLE cycle.
- No arbitration outside IDLE. Requests raised during SHIFT or GAP wait; at most one ack per frame.
- req and req_data are sampled only at the arbitration edge; later changes do not affect the frame in progress.
- Requesters may drop req in the ack cycle. A req dropped before its ack is simply never granted.
- Width rules: timer is $clog2(CLKS_PER_BIT)+1 bits and wraps at CLKS_PER_BIT-1. The bit index is 3 bits.
- Reset mid-frame: frame abandoned with no done pulse, no partial ack retained, rr pointer back to 0.

Optional Feature:
- Macro: SER_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req[0] highest down to req[3] lowest. The rr pointer is not implemented.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single request, CLKS_PER_BIT=4: req[2]=1, byte2=0xA5.
  - ack=4'b0100 one cycle after req is seen; cs_n low 64 cycles.
  - sdo sampled on sclk rising edges = 1,0,1,0,0,1,0,1.
  - done pulse at cs_n rise; busy falls 4 cycles later.
- All four held: req=4'b1111, bytes 0x11, 0x22, 0x33, 0x44 from reset.
  - Frames in order 0,1,2,3, each ack one-hot.
  - Keep req[0] high afterward: 5th frame = 0x11.
- Round-robin: after serving requester 2, raise req[0] and req[3] together.
  - Requester 3 granted first, then 0.
  - With SER_TX_ARB_FIXED_PRIO_EN defined, requester 0 is granted first.
- Reset mid-frame: assert rst during bit 3.
  - Same cycle: cs_n=1, sclk=0, sdo=0, busy=0, no done pulse.
  - After release, simultaneous req[1] and req[0]: requester 0 granted.
- CLKS_PER_BIT=1, byte 0xFF:
  - sclk toggles every cycle, cs_n low 16 cycles, sdo=1 throughout the frame.
  - Gap is 1 cycle.
- Withdrawn request: pulse req[1] high for one cycle during SHIFT of another frame.
  - No ack[1] ever; next IDLE with req=0 stays idle, busy=0.
